mux_arb_nx1: RTL and testbench
==============================

// Module: mux_arb_nx1
// PURPOSE
//  Parametrised N:1 datapath mux with valid/ready handshake and one registered output stage.
//  Generalises the 2:1 combinational mux to NCH channels of TAM bits.
//  Two selection modes: fixed (MUX_sel picks the channel) or round-robin arbitration.
//  Used where several NRISC units contend for one bus (e.g. register-file write-back).
// PARAMETERS
//  TAM   16  data width per channel, bits
//  NCH   4   number of input channels, 2..16
//  SELW  clog2(NCH)  select/grant width; derived, never overridden
// PORTS
//  clk             in   1         clock; all state updates on posedge
//  rst             in   1         asynchronous, active-low reset
//  MUX_mode        in   1         0 = fixed select, 1 = round-robin
//  MUX_sel         in   SELW      channel number used in fixed mode
//  MUX_in          in   NCH*TAM   channel i occupies bits [i*TAM +: TAM]
//  MUX_in_valid    in   NCH       channel i offers a word
//  MUX_in_ready    out  NCH       channel i word accepted this cycle (one-hot or zero)
//  MUX_Out         out  TAM       registered output word
//  MUX_out_valid   out  1         MUX_Out holds a word
//  MUX_out_ready   in   1         consumer takes MUX_Out this cycle
//  MUX_grant       out  SELW      channel that sourced the current MUX_Out
// BEHAVIOUR
//  Reset (rst=0, async): MUX_out_valid=0, MUX_Out=0, MUX_grant=0, rr_ptr=NCH-1.
//   Any word held in the output register is dropped. MUX_in_ready=0 while rst=0.
//  Load enable: load = !MUX_out_valid | MUX_out_ready (supports back-to-back, 1 word/cycle).
//  Fixed mode: candidate = MUX_sel. If MUX_sel >= NCH, there is no candidate.
//  Round-robin mode: candidate = first i with MUX_in_valid[i], scanning rr_ptr+1,
//   rr_ptr+2, ... with wrap modulo NCH. rr_ptr = last accepted channel.
//  Transfer: when load & candidate valid & MUX_in_valid[candidate]:
//   MUX_in_ready[candidate]=1; on next edge MUX_Out<=word, MUX_grant<=candidate,
//   MUX_out_valid<=1. rr_ptr<=candidate, in both modes.
//  Latency: 1 cycle from the input handshake to MUX_out_valid.
//  No transfer while load=1: MUX_out_valid<=0 on next edge (if consumed).
//   MUX_Out and MUX_grant hold their last values.
//  Stall: MUX_out_valid=1 & MUX_out_ready=0 -> all MUX_in_ready=0; MUX_Out/MUX_grant stable.
//  MUX_in_ready is combinational from valid/sel/mode/out_ready; at most one bit set.
//  Mode or MUX_sel change takes effect on the same cycle's arbitration.
//   The word already in the output register is unaffected.
//  Simultaneous events: consume + new load on the same edge -> new word replaces the old.
//   No bubble and no loss.
//  Single requester in round-robin: granted every cycle regardless of rr_ptr.
//  Producer rule: MUX_in_valid and data are held until ready; the block does not check this.
// TESTING
//  1 Reset: rst=0 mid-transfer with out_valid=1 -> out_valid=0, MUX_Out=0, grant=0 immediately.
//  2 Fixed: mode=0, sel=2, all valid, in2=16'hA5A5, out_ready=1
//     -> ready=4'b0100; next cycle MUX_Out=A5A5, grant=2.
//  3 Round-robin: mode=1, all 4 valid, out_ready=1 for 8 cycles after reset
//     -> grants 0,1,2,3,0,1,2,3; one word per cycle.
//  4 Backpressure: out_ready=0 for 3 cycles with out_valid=1
//     -> in_ready=0, MUX_Out stable; release -> next word follows with no bubble.
//  5 Wrap/skip: rr_ptr=3, valid=4'b0100 -> channel 2 granted; then valid=4'b1001 -> channel 3.
//  6 Random: a scoreboard checks per-channel order and no loss/duplication.
//     Also checks sel>=NCH (NCH=3) -> no grant.

Source files
------------

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1 -- parametrised N:1 datapath mux with valid/ready handshake
// and a single registered output stage.
//
// Several producers (NCH channels of TAM bits each) contend for one
// consumer. The channel is chosen either by a fixed select or by
// round-robin arbitration. The winner's word is captured into the output
// register one cycle after its handshake. Back-to-back transfers sustain
// one word per cycle.
//
// Ports
//   clk            clock, all state changes on posedge
//   rst            asynchronous reset, active low
//   MUX_mode       0 = fixed select (MUX_sel), 1 = round-robin
//   MUX_sel        channel number used in fixed mode (>= NCH selects none)
//   MUX_in         packed channel words, channel i at [i*TAM +: TAM]
//   MUX_in_valid   per-channel offer
//   MUX_in_ready   per-channel accept, one-hot or zero, combinational
//   MUX_Out        registered output word
//   MUX_out_valid  MUX_Out holds a word
//   MUX_out_ready  consumer takes MUX_Out this cycle
//   MUX_grant      channel that sourced the current MUX_Out
module mux_arb_nx1 #(
    parameter  int TAM  = 16,
    parameter  int NCH  = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MUX_mode,
    input  logic [SELW-1:0]      MUX_sel,
    input  logic [NCH*TAM-1:0]   MUX_in,
    input  logic [NCH-1:0]       MUX_in_valid,
    output logic [NCH-1:0]       MUX_in_ready,
    output logic [TAM-1:0]       MUX_Out,
    output logic                 MUX_out_valid,
    input  logic                 MUX_out_ready,
    output logic [SELW-1:0]      MUX_grant
);

    logic [SELW-1:0] rr_ptr;
    logic            vld_p1;
    logic [TAM-1:0]  word_p1;
    logic [SELW-1:0] grant_p1;

    logic            load;
    logic            fx_ok;
    logic            rr_ok;
    logic [SELW-1:0] rr_cand;
    logic            cand_ok;
    logic [SELW-1:0] cand;
    logic            xfer;
    logic [TAM-1:0]  word_p0;

    // ---- stage p0: arbitration and input selection ----

    // The output register may accept a new word when empty or being drained.
    assign load = !vld_p1 || MUX_out_ready;

    // Fixed mode: a select value with no matching channel yields no candidate.
    always_comb begin
        fx_ok = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (MUX_sel == SELW'(i)) begin
                fx_ok = MUX_in_valid[i];
            end
        end
    end

    // Round-robin: first valid channel after the last accepted one, wrapping.
    // Scanning k = 1..NCH ends on rr_ptr itself, so a lone requester is
    // always granted.
    always_comb begin
        rr_ok   = 1'b0;
        rr_cand = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!rr_ok && MUX_in_valid[SELW'((int'(rr_ptr) + k) % NCH)]) begin
                rr_ok   = 1'b1;
                rr_cand = SELW'((int'(rr_ptr) + k) % NCH);
            end
        end
    end

    assign cand    = MUX_mode ? rr_cand : MUX_sel;
    assign cand_ok = MUX_mode ? rr_ok   : fx_ok;

    // While reset is asserted, nothing is accepted.
    assign xfer = rst && load && cand_ok;

    always_comb begin
        word_p0      = '0;
        MUX_in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cand == SELW'(i)) begin
                word_p0         = MUX_in[i*TAM +: TAM];
                MUX_in_ready[i] = xfer;
            end
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            word_p1  <= '0;
            grant_p1 <= '0;
            rr_ptr   <= SELW'(NCH - 1);
        end else begin
            if (load) begin
                vld_p1 <= xfer;
            end
            if (xfer) begin
                word_p1  <= word_p0;
                grant_p1 <= cand;
                rr_ptr   <= cand;
            end
        end
    end

    assign MUX_Out       = word_p1;
    assign MUX_out_valid = vld_p1;
    assign MUX_grant     = grant_p1;

endmodule

// File: tb/tb_mux_arb_nx1.sv
module tb_mux_arb_nx1;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode;
    logic [1:0]  sel;
    logic [63:0] din;
    logic [3:0]  vin;
    logic [3:0]  rdy;
    logic [15:0] dout;
    logic        ov;
    logic        ordy;
    logic [1:0]  gnt;

    logic        mode3;
    logic [1:0]  sel3;
    logic [47:0] din3;
    logic [2:0]  vin3;
    logic [2:0]  rdy3;
    logic [15:0] dout3;
    logic        ov3;
    logic        ordy3;
    logic [1:0]  gnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arb_nx1 #(.TAM(16), .NCH(4)) dut (
        .clk(clk), .rst(rst), .MUX_mode(mode), .MUX_sel(sel), .MUX_in(din),
        .MUX_in_valid(vin), .MUX_in_ready(rdy), .MUX_Out(dout),
        .MUX_out_valid(ov), .MUX_out_ready(ordy), .MUX_grant(gnt)
    );

    mux_arb_nx1 #(.TAM(16), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .MUX_mode(mode3), .MUX_sel(sel3), .MUX_in(din3),
        .MUX_in_valid(vin3), .MUX_in_ready(rdy3), .MUX_Out(dout3),
        .MUX_out_valid(ov3), .MUX_out_ready(ordy3), .MUX_grant(gnt3)
    );

    task automatic do_reset();
        rst = 1'b0;
        vin = '0; vin3 = '0; ordy = 1'b1; ordy3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        // Reset state while everything requests.
        mode = 1'b1; vin = 4'hF; ordy = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++;
        if (ov !== 1'b0 || dout !== 16'h0 || gnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got ov=%b out=%h gnt=%0d want 0/0000/0", ov, dout, gnt);
        end
        checks++;
        if (rdy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", rdy);
        end
        // Reset mid-transfer with a held word.
        do_reset();
        mode = 1'b0; sel = 2'd3; vin = 4'hF; ordy = 1'b0;
        din = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        @(negedge clk);
        checks++;
        if (ov !== 1'b1 || dout !== 16'h4444 || gnt !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset_load got ov=%b out=%h gnt=%0d want 1/4444/3", ov, dout, gnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ov !== 1'b0 || dout !== 16'h0 || gnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got ov=%b out=%h gnt=%0d want 0/0000/0", ov, dout, gnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; vin = 4'hF; ordy = 1'b1;
        din = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        #1;
        checks++;
        if (rdy !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready got %b want 0100", rdy);
        end
        @(negedge clk);
        checks++;
        if (ov !== 1'b1 || dout !== 16'hA5A5 || gnt !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out got ov=%b out=%h gnt=%0d want 1/a5a5/2", ov, dout, gnt);
        end
        sel = 2'd1;
        #1;
        checks++;
        if (rdy !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_sel_change got %b want 0010", rdy);
        end
        @(negedge clk);
        checks++;
        if (ov !== 1'b1 || dout !== 16'h2222 || gnt !== 2'd1) begin
            errors++;
            $display("FAIL fixed_out2 got ov=%b out=%h gnt=%0d want 1/2222/1", ov, dout, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy;
        logic [15:0] exp_word;
        do_reset();
        mode = 1'b1; vin = 4'hF; ordy = 1'b1;
        din = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        for (int c = 0; c < 8; c++) begin
            exp_rdy  = 4'b0001 << (c % 4);
            exp_word = 16'hD000 + 16'(c % 4);
            #1;
            checks++;
            if (rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b want %b", c, rdy, exp_rdy);
            end
            @(negedge clk);
            checks++;
            if (ov !== 1'b1 || gnt !== 2'(c % 4) || dout !== exp_word) begin
                errors++;
                $display("FAIL rr_grant[%0d] got ov=%b gnt=%0d out=%h want 1/%0d/%h",
                         c, ov, gnt, dout, c % 4, exp_word);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode = 1'b1; vin = 4'hF; ordy = 1'b1;
        din = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        @(negedge clk);
        ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rdy !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready[%0d] got %b want 0000", c, rdy);
            end
            @(negedge clk);
            checks++;
            if (ov !== 1'b1 || dout !== 16'hB000 || gnt !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got ov=%b out=%h gnt=%0d want 1/b000/0",
                         c, ov, dout, gnt);
            end
        end
        ordy = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'b0010) begin
            errors++;
            $display("FAIL release_ready got %b want 0010", rdy);
        end
        @(negedge clk);
        checks++;
        if (ov !== 1'b1 || dout !== 16'hB001 || gnt !== 2'd1) begin
            errors++;
            $display("FAIL release_next got ov=%b out=%h gnt=%0d want 1/b001/1", ov, dout, gnt);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        mode = 1'b1; ordy = 1'b1; vin = 4'b0100;
        din = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        #1;
        checks++;
        if (rdy !== 4'b0100) begin
            errors++;
            $display("FAIL skip_ready got %b want 0100", rdy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'd2 || dout !== 16'hC002) begin
            errors++;
            $display("FAIL skip_grant got gnt=%0d out=%h want 2/c002", gnt, dout);
        end
        vin = 4'b1001;
        #1;
        checks++;
        if (rdy !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready got %b want 1000", rdy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'd3 || dout !== 16'hC003) begin
            errors++;
            $display("FAIL wrap_grant got gnt=%0d out=%h want 3/c003", gnt, dout);
        end
        vin = 4'b0000;
        @(negedge clk);
        checks++;
        if (ov !== 1'b0 || gnt !== 2'd3 || dout !== 16'hC003) begin
            errors++;
            $display("FAIL idle_hold got ov=%b gnt=%0d out=%h want 0/3/c003", ov, gnt, dout);
        end
    endtask

    task automatic test_sel_oob();
        do_reset();
        mode3 = 1'b0; sel3 = 2'd3; vin3 = 3'b111; ordy3 = 1'b1;
        din3 = {16'h3332, 16'h3331, 16'h3330};
        #1;
        checks++;
        if (rdy3 !== 3'b000) begin
            errors++;
            $display("FAIL oob_ready got %b want 000", rdy3);
        end
        @(negedge clk);
        checks++;
        if (ov3 !== 1'b0) begin
            errors++;
            $display("FAIL oob_valid got %b want 0", ov3);
        end
        sel3 = 2'd2;
        #1;
        checks++;
        if (rdy3 !== 3'b100) begin
            errors++;
            $display("FAIL sel2_ready got %b want 100", rdy3);
        end
        @(negedge clk);
        checks++;
        if (ov3 !== 1'b1 || gnt3 !== 2'd2 || dout3 !== 16'h3332) begin
            errors++;
            $display("FAIL sel2_out got ov=%b gnt=%0d out=%h want 1/2/3332", ov3, gnt3, dout3);
        end
        // Round-robin wraps modulo 3: after channel 2 comes 0, 1, 2.
        mode3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (gnt3 !== 2'(c % 3) || dout3 !== 16'h3330 + 16'(c % 3)) begin
                errors++;
                $display("FAIL rr3_grant[%0d] got gnt=%0d out=%h want %0d", c, gnt3, dout3, c % 3);
            end
        end
        vin3 = '0;
    endtask

    task automatic test_random();
        int         sent[4];
        int         recv[4];
        logic [3:0] acc;
        int         delivered;
        delivered = 0;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            recv[i] = 0;
        end
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    sent[i]++;
                    vin[i] = 1'b0;
                end
                if (!vin[i] && $urandom_range(0, 2) != 0) vin[i] = 1'b1;
                din[i*16 +: 16] = {4'(i), 12'(sent[i])};
            end
            if (cyc >= 280) vin = '0;
            mode = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            ordy = (cyc >= 280) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            acc = rdy;
            checks++;
            if (((rdy & (rdy - 4'd1)) != 4'd0) || ((rdy & ~vin) != 4'd0)) begin
                errors++;
                $display("FAIL rand_ready_onehot[%0d] got rdy=%b vin=%b", cyc, rdy, vin);
            end
            if (ov && ordy) begin
                checks++;
                if (dout[15:12] !== {2'b00, gnt} || dout[11:0] !== 12'(recv[gnt])) begin
                    errors++;
                    $display("FAIL rand_order[%0d] got out=%h gnt=%0d want seq %0d",
                             cyc, dout, gnt, recv[gnt]);
                end
                recv[gnt]++;
                delivered++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (recv[i] != sent[i]) begin
                errors++;
                $display("FAIL rand_count[%0d] got recv=%0d want sent=%0d", i, recv[i], sent[i]);
            end
        end
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rand_throughput got %0d want >= 50", delivered);
        end
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0; sel = '0; din = '0; vin = '0; ordy = 1'b0;
        mode3 = 1'b0; sel3 = '0; din3 = '0; vin3 = '0; ordy3 = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_back_to_back();
        test_wrap_skip();
        test_sel_oob();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
